// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-port controller for a byte-masked register file. After reset it zeroes
//   registers 1..NUM_REGS-1, one per cycle. It then shares the single write port
//   between two writeback requesters using round-robin valid/ready arbitration.
//   All RF_* outputs and INIT_DONE come straight from registers.
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   SOFT_INIT            re-run the zeroing sweep (honoured in RUN only)
//   REQn_VALID/ADDR/     writeback request n (n = 0, 1)
//   DATA/MASK
//   REQn_READY           request n accepted when VALID is also high
//   RF_WE/W_ADDR/        registered register-file write port
//   W_DATA/W_MASK
//   INIT_DONE            high while in RUN
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                SOFT_INIT,
    input  logic                REQ0_VALID,
    input  logic [ADDR_W-1:0]   REQ0_ADDR,
    input  logic [DATA_W-1:0]   REQ0_DATA,
    input  logic [DATA_W/8-1:0] REQ0_MASK,
    output logic                REQ0_READY,
    input  logic                REQ1_VALID,
    input  logic [ADDR_W-1:0]   REQ1_ADDR,
    input  logic [DATA_W-1:0]   REQ1_DATA,
    input  logic [DATA_W/8-1:0] REQ1_MASK,
    output logic                REQ1_READY,
    output logic                RF_WE,
    output logic [ADDR_W-1:0]   RF_W_ADDR,
    output logic [DATA_W-1:0]   RF_W_DATA,
    output logic [DATA_W/8-1:0] RF_W_MASK,
    output logic                INIT_DONE
);

    localparam logic [ADDR_W-1:0] LastReg  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FirstReg = ADDR_W'(1);

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    // ptr_q == 0 favours REQ0 when both requesters are valid.
    logic                ptr_q, ptr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W/8-1:0] mask_q, mask_d;
    logic                done_q, done_d;

    logic arb_en;
    logic rdy0, rdy1;
    logic gnt0, gnt1;

    // Readiness is combinational. When both are valid exactly one READY is high,
    // so at most one grant happens per cycle.
    always_comb begin
        arb_en = (state_q == StRun) && !SOFT_INIT;
        rdy0   = arb_en && (!REQ1_VALID || !ptr_q);
        rdy1   = arb_en && (!REQ0_VALID ||  ptr_q);
        gnt0   = REQ0_VALID && rdy0;
        gnt1   = REQ1_VALID && rdy1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;

        unique case (state_q)
            StInit: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                mask_d = '1;
                cnt_d  = cnt_q + FirstReg;
                if (cnt_q == LastReg) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (SOFT_INIT) begin
                    state_d = StInit;
                    cnt_d   = FirstReg;
                end else if (gnt0) begin
                    // Writes to r0 or with an empty mask are consumed but not issued.
                    we_d   = (REQ0_ADDR != '0) && (REQ0_MASK != '0);
                    addr_d = REQ0_ADDR;
                    data_d = REQ0_DATA;
                    mask_d = REQ0_MASK;
                    ptr_d  = 1'b1;
                end else if (gnt1) begin
                    we_d   = (REQ1_ADDR != '0) && (REQ1_MASK != '0);
                    addr_d = REQ1_ADDR;
                    data_d = REQ1_DATA;
                    mask_d = REQ1_MASK;
                    ptr_d  = 1'b0;
                end
            end
        endcase

        // Registered copy of (state == RUN).
        done_d = (state_d == StRun);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StInit;
            cnt_q   <= FirstReg;
            ptr_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

    assign REQ0_READY = rdy0;
    assign REQ1_READY = rdy1;
    assign RF_WE      = we_q;
    assign RF_W_ADDR  = addr_q;
    assign RF_W_DATA  = data_q;
    assign RF_W_MASK  = mask_q;
    assign INIT_DONE  = done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, hand-written
// SOFT_INIT / mid-sweep reset sequences, then random traffic against a
// transaction-level reference model.
module tb_regfile_wb_arbiter;

    localparam int NR = 32;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int MW = DW / 8;

    logic          CLK;
    logic          RST_N;
    logic          SOFT_INIT;
    logic          REQ0_VALID, REQ1_VALID;
    logic [AW-1:0] REQ0_ADDR, REQ1_ADDR;
    logic [DW-1:0] REQ0_DATA, REQ1_DATA;
    logic [MW-1:0] REQ0_MASK, REQ1_MASK;
    logic          REQ0_READY, REQ1_READY;
    logic          RF_WE;
    logic [AW-1:0] RF_W_ADDR;
    logic [DW-1:0] RF_W_DATA;
    logic [MW-1:0] RF_W_MASK;
    logic          INIT_DONE;

    regfile_wb_arbiter #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .ADDR_W   (AW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SOFT_INIT  (SOFT_INIT),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ0_DATA  (REQ0_DATA),
        .REQ0_MASK  (REQ0_MASK),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ1_DATA  (REQ1_DATA),
        .REQ1_MASK  (REQ1_MASK),
        .REQ1_READY (REQ1_READY),
        .RF_WE      (RF_WE),
        .RF_W_ADDR  (RF_W_ADDR),
        .RF_W_DATA  (RF_W_DATA),
        .RF_W_MASK  (RF_W_MASK),
        .INIT_DONE  (INIT_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a mode flag, the next register to sweep, whose turn it is
    // when both ask, and the write expected on the port after the next edge.
    bit            m_run;
    int            m_next;
    int            m_turn;
    bit            m_g0, m_g1;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;

    task automatic model_reset();
        m_run  = 0;
        m_next = 1;
        m_turn = 0;
        m_we   = 0;
        m_addr = '0;
        m_data = '0;
        m_mask = '0;
        m_g0   = 0;
        m_g1   = 0;
    endtask

    // Readies from the rules: nobody while sweeping or on a SOFT_INIT cycle;
    // otherwise a requester may go unless the other one is waiting and it is
    // not this requester's turn.
    task automatic model_ready(output bit r0, output bit r1);
        if (!m_run || SOFT_INIT) begin
            r0 = 0;
            r1 = 0;
        end else begin
            r0 = !REQ1_VALID || (m_turn == 0);
            r1 = !REQ0_VALID || (m_turn == 1);
        end
    endtask

    // Before the edge: compare readies, then advance the model over the edge.
    task automatic half_pre();
        bit r0, r1;
        #2;
        model_ready(r0, r1);
        chk("ready0", REQ0_READY, r0);
        chk("ready1", REQ1_READY, r1);
        m_g0 = REQ0_VALID && r0;
        m_g1 = REQ1_VALID && r1;
        if (!m_run) begin
            m_we   = 1;
            m_addr = AW'(m_next);
            m_data = '0;
            m_mask = '1;
            if (m_next == NR - 1) m_run = 1;
            m_next++;
        end else if (SOFT_INIT) begin
            m_we   = 0;
            m_run  = 0;
            m_next = 1;
        end else if (m_g0) begin
            m_we   = (REQ0_ADDR != 0) && (REQ0_MASK != 0);
            m_addr = REQ0_ADDR;
            m_data = REQ0_DATA;
            m_mask = REQ0_MASK;
            m_turn = 1;
        end else if (m_g1) begin
            m_we   = (REQ1_ADDR != 0) && (REQ1_MASK != 0);
            m_addr = REQ1_ADDR;
            m_data = REQ1_DATA;
            m_mask = REQ1_MASK;
            m_turn = 0;
        end else begin
            m_we = 0;
        end
    endtask

    task automatic half_post();
        @(posedge CLK);
        #1;
        chk("rf_we", RF_WE, m_we);
        chk("init_done", INIT_DONE, m_run);
        if (m_we) begin
            chk("rf_addr", RF_W_ADDR, m_addr);
            chk("rf_data", RF_W_DATA, m_data);
            chk("rf_mask", RF_W_MASK, m_mask);
        end
    endtask

    task automatic tick();
        half_pre();
        half_post();
    endtask

    task automatic set_req(input int idx, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        if (idx == 0) begin
            REQ0_VALID = v; REQ0_ADDR = a; REQ0_DATA = d; REQ0_MASK = m;
        end else begin
            REQ1_VALID = v; REQ1_ADDR = a; REQ1_DATA = d; REQ1_MASK = m;
        end
    endtask

    task automatic rand_req(input int idx);
        logic [MW-1:0] m;
        m = MW'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) m = '0;
        set_req(idx, $urandom_range(0, 2) != 0, AW'($urandom_range(0, NR - 1)),
                {$urandom, $urandom}, m);
    endtask

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [MW-1:0] m0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [MW-1:0] m1;
        logic          r0;
        logic          r1;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } vec_t;

    localparam logic [DW-1:0] DA   = 64'hA;
    localparam logic [DW-1:0] DB   = 64'hB;
    localparam logic [DW-1:0] DP   = 64'h1122334455667788;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    vec_t vecs [15];

    initial begin
        // Starting in RUN with REQ0 favoured.
        vecs[0]  = '{1, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 1, 0, 1, 3, DA, 8'hFF};
        vecs[1]  = '{1, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 0, 1, 1, 5, DB, 8'hFF};
        vecs[2]  = '{1, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 1, 0, 1, 3, DA, 8'hFF};
        vecs[3]  = '{1, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 0, 1, 1, 5, DB, 8'hFF};
        vecs[4]  = '{0, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 1, 1, 1, 5, DB, 8'hFF};
        vecs[5]  = '{0, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 1, 1, 1, 5, DB, 8'hFF};
        vecs[6]  = '{0, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 1, 1, 1, 5, DB, 8'hFF};
        vecs[7]  = '{1, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 1, 0, 1, 3, DA, 8'hFF};
        vecs[8]  = '{1, 0, ONES, 8'hFF, 0, 5, DB, 8'hFF, 1, 1, 0, 0, 0, 0};
        vecs[9]  = '{1, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 0, 1, 1, 5, DB, 8'hFF};
        vecs[10] = '{1, 7, DA, 8'h00, 0, 5, DB, 8'hFF, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 0, 1, 1, 5, DB, 8'hFF};
        vecs[12] = '{1, 9, DP, 8'h81, 0, 5, DB, 8'hFF, 1, 0, 1, 9, DP, 8'h81};
        vecs[13] = '{0, 3, DA, 8'hFF, 0, 5, DB, 8'hFF, 1, 1, 0, 0, 0, 0};
        vecs[14] = '{1, 3, DA, 8'hFF, 1, 5, DB, 8'hFF, 0, 1, 1, 5, DB, 8'hFF};

        RST_N     = 1'b0;
        SOFT_INIT = 1'b0;
        set_req(0, 1, 3, DA, 8'hFF);
        set_req(1, 1, 5, DB, 8'hFF);
        model_reset();

        // Reset state.
        #12;
        chk("rst_we", RF_WE, 0);
        chk("rst_addr", RF_W_ADDR, 0);
        chk("rst_data", RF_W_DATA, 0);
        chk("rst_mask", RF_W_MASK, 0);
        chk("rst_done", INIT_DONE, 0);
        chk("rst_ready0", REQ0_READY, 0);
        chk("rst_ready1", REQ1_READY, 0);

        // Initial sweep with both requesters pushing.
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 1; i < NR; i++) begin
            tick();
            chk("sweep_addr", RF_W_ADDR, i);
            chk("sweep_we", RF_WE, 1);
            chk("sweep_mask", RF_W_MASK, 8'hFF);
            chk("sweep_done", INIT_DONE, i == NR - 1);
        end

        // Directed arbitration table.
        for (int i = 0; i < 15; i++) begin
            set_req(0, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].m0);
            set_req(1, vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].m1);
            half_pre();
            chk("tbl_ready0", REQ0_READY, vecs[i].r0);
            chk("tbl_ready1", REQ1_READY, vecs[i].r1);
            half_post();
            chk("tbl_we", RF_WE, vecs[i].we);
            if (vecs[i].we) begin
                chk("tbl_addr", RF_W_ADDR, vecs[i].addr);
                chk("tbl_data", RF_W_DATA, vecs[i].data);
                chk("tbl_mask", RF_W_MASK, vecs[i].mask);
            end
        end

        // SOFT_INIT right after a grant: the registered write still shows.
        set_req(0, 1, 3, DA, 8'hFF);
        set_req(1, 0, 5, DB, 8'hFF);
        tick();
        SOFT_INIT = 1'b1;
        #2;
        chk("soft_ready0", REQ0_READY, 0);
        chk("soft_prev_we", RF_WE, 1);
        chk("soft_prev_addr", RF_W_ADDR, 3);
        half_pre();
        half_post();
        chk("soft_done_fall", INIT_DONE, 0);
        chk("soft_no_write", RF_WE, 0);
        // SOFT_INIT held into the sweep has no effect there.
        for (int i = 1; i < NR; i++) begin
            SOFT_INIT = (i <= 3);
            tick();
            chk("resweep_addr", RF_W_ADDR, i);
        end
        SOFT_INIT = 1'b0;
        tick();
        chk("post_soft_we", RF_WE, 1);
        chk("post_soft_addr", RF_W_ADDR, 3);

        // Reset while the sweep counter is at 10.
        SOFT_INIT = 1'b1;
        tick();
        SOFT_INIT = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        chk("pre_rst_addr", RF_W_ADDR, 9);
        RST_N = 1'b0;
        #1;
        chk("midrst_we", RF_WE, 0);
        chk("midrst_done", INIT_DONE, 0);
        chk("midrst_ready0", REQ0_READY, 0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("restart_addr", RF_W_ADDR, 1);
        for (int i = 2; i < NR; i++) tick();

        // Random traffic; requests stay stable until accepted.
        rand_req(0);
        rand_req(1);
        for (int c = 0; c < 500; c++) begin
            SOFT_INIT = ($urandom_range(0, 59) == 0);
            tick();
            if (!REQ0_VALID || m_g0) rand_req(0);
            if (!REQ1_VALID || m_g1) rand_req(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
